// File: rtl/rv32_register_file_mp.sv
// rtl/rv32_register_file_mp.sv - parametrised multi-port integer register file with busy-bit scoreboard
// Registered reads; same-cycle read/write behaviour selected by WRITE_FIRST.
module rv32_register_file_mp #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int NRD         = 2,
  parameter int NWR         = 1,
  parameter int SP_INDEX    = 2,
  parameter int SP_RESET    = 4096,
  parameter int WRITE_FIRST = 1,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [NREGS-1:0]    busy_q;
  logic [NREGS-1:0]    busy_d;
  logic [NREGS-1:0]    written;
  logic [NRD*XLEN-1:0] rd_data_q;
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD-1:0]      rd_busy_q;
  logic [NRD-1:0]      rd_busy_d;

  // Later write ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    written = '0;
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        regs_d[wr_addr[j*AW +: AW]]  = wr_data[j*XLEN +: XLEN];
        written[wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
  end

  // A newly issued producer keeps the register busy even if an older one retires now.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy_d[r] = (busy_q[r] & ~written[r]) | (sb_set && (sb_addr == AW'(r)));
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        if (WRITE_FIRST != 0) begin
          rd_data_d[i*XLEN +: XLEN] = regs_d[rd_addr[i*AW +: AW]];
          rd_busy_d[i]              = busy_d[rd_addr[i*AW +: AW]];
        end else begin
          rd_data_d[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
          rd_busy_d[i]              = busy_q[rd_addr[i*AW +: AW]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        if (r == SP_INDEX) begin
          regs_q[r] <= XLEN'(SP_RESET);
        end else begin
          regs_q[r] <= '0;
        end
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_rv32_register_file_mp.sv
// tb/tb_rv32_register_file_mp.sv - scoreboard bench for rv32_register_file_mp (write-first and read-first)
// Both variants share stimulus; an array model predicts each cycle's read results.
module tb_rv32_register_file_mp;

  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data_wf, rd_data_rf;
  logic [NRD-1:0]      rd_busy_wf, rd_busy_rf;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic                sb_set = 1'b0;
  logic [AW-1:0]       sb_addr = '0;

  always #5 clk = ~clk;

  rv32_register_file_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR), .SP_INDEX(2),
                          .SP_RESET(4096), .WRITE_FIRST(1)) dut_wf (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_wf), .rd_busy(rd_busy_wf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr));

  rv32_register_file_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR), .SP_INDEX(2),
                          .SP_RESET(4096), .WRITE_FIRST(0)) dut_rf (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_rf), .rd_busy(rd_busy_rf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr));

  typedef struct packed {
    logic [NRD*XLEN-1:0] d_wf;
    logic [NRD*XLEN-1:0] d_rf;
    logic [NRD-1:0]      b_wf;
    logic [NRD-1:0]      b_rf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mreg  [32];
  logic        mbusy [32];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string name, input int port, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s port%0d actual=%h required=%h", name, port, act, req);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mreg[r]  = (r == 2) ? 32'd4096 : 32'd0;
      mbusy[r] = 1'b0;
    end
  endtask

  // One clock of stimulus; the expected outputs after the coming edge are queued.
  task automatic step(input logic r, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic s, input logic [4:0] sa);
    exp_t       e;
    logic [4:0] ra [2];
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0}; sb_set = s; sb_addr = sa;
    ra[0] = ra0; ra[1] = ra1;
    e = '0;
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        e.d_rf[i*32 +: 32] = (ra[i] == 0) ? 32'd0 : mreg[ra[i]];
        e.b_rf[i]          = (ra[i] == 0) ? 1'b0  : mbusy[ra[i]];
      end
      if (we[0] && wa0 != 0) begin mreg[wa0] = wd0; mbusy[wa0] = 1'b0; end
      if (we[1] && wa1 != 0) begin mreg[wa1] = wd1; mbusy[wa1] = 1'b0; end
      if (s && sa != 0) mbusy[sa] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        e.d_wf[i*32 +: 32] = (ra[i] == 0) ? 32'd0 : mreg[ra[i]];
        e.b_wf[i]          = (ra[i] == 0) ? 1'b0  : mbusy[ra[i]];
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NRD; i++) begin
          chk("data_wf", i, rd_data_wf[i*32 +: 32], e.d_wf[i*32 +: 32]);
          chk("data_rf", i, rd_data_rf[i*32 +: 32], e.d_rf[i*32 +: 32]);
          chk("busy_wf", i, 32'(rd_busy_wf[i]), 32'(e.b_wf[i]));
          chk("busy_rf", i, 32'(rd_busy_rf[i]), 32'(e.b_rf[i]));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    model_reset();
    // reset, then SP and zero reads
    step(1, 2'b00, 0, 0, 0, 0, 0, 2, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0, 5, 2, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 2, 0, 0);
    step(0, 2'b01, 2, 32'h10, 0, 0, 5, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 2, 2, 0, 0);
    // read latency
    step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 5, 5, 0, 0);
    // same-cycle read/write
    step(0, 2'b01, 7, 32'h1, 0, 0, 0, 0, 0, 0);
    step(0, 2'b01, 7, 32'h2, 0, 0, 7, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 7, 7, 0, 0);
    // x0 and write-port collision
    step(0, 2'b01, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
    step(0, 2'b11, 9, 32'hA, 9, 32'hB, 0, 9, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 9, 0, 0, 0);
    // scoreboard set, clear, set-wins, reset discards
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 12);
    step(0, 2'b00, 0, 0, 0, 0, 12, 0, 1, 0);
    step(0, 2'b01, 12, 32'h33, 0, 0, 12, 12, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 12, 0, 0, 0);
    step(0, 2'b10, 0, 0, 12, 32'h44, 12, 12, 1, 12);
    step(0, 2'b00, 0, 0, 0, 0, 12, 0, 0, 0);
    step(1, 2'b01, 12, 32'h55, 0, 0, 12, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 12, 2, 0, 0);
    // randomized traffic over a narrow address range to force collisions
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 63) == 0),
           2'($urandom_range(0, 3)),
           5'($urandom_range(0, 15)), $urandom(),
           5'($urandom_range(0, 15)), $urandom(),
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)));
    end
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32_register_file_mp.md
Name: rv32_register_file_mp

Overview:
- Parametrised multi-port integer register file. Next generation of the single-write, dual-read RV32 register file.
- Adds configurable register count, width, read-port count and write-port count.
- Adds selectable write-first/read-first same-cycle behaviour and an integrated busy-bit scoreboard for pending writebacks.
- Sits between decode (read and scoreboard query) and writeback (NWR retire lanes) of the CPU pipeline.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NREGS)
NRD, 2, number of read ports (1..4)
NWR, 1, number of write ports (1..2)
SP_INDEX, 2, register index given a non-zero reset value
SP_RESET, 4096, reset value of register SP_INDEX
WRITE_FIRST, 1, 1 = same-cycle write to a read address is forwarded; 0 = read returns the old value

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  registered busy flag of the addressed register per read port
wr_en  in  NWR  write enable per write port
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
sb_set  in  1  mark register sb_addr as pending-write (issue of producer)
sb_addr  in  AW  scoreboard set address

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset applies on the rising edge with rst=1.
- Reset state:
  - All registers become 0, except register SP_INDEX, which becomes SP_RESET.
  - All busy bits become 0.
  - rd_data and rd_busy become 0.
  - rst has priority over every write, set and read in that cycle.
- Read latency: 1 cycle. rd_addr is sampled at edge N; rd_data and rd_busy are valid after edge N and held until edge N+1.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and sb_set targeting address 0 are ignored.
- Writes: on an edge with wr_en[j]=1 and wr_addr[j]!=0, register wr_addr[j] takes wr_data[j].
- Write collision: if two enabled write ports target the same address in one cycle, the higher port index wins.
- Same-cycle read/write to the same non-zero address:
  - WRITE_FIRST=1: rd_data captures the winning wr_data.
  - WRITE_FIRST=0: rd_data captures the pre-write register value.
- Scoreboard update per edge, for each non-zero register r:
  - busy[r] next = (busy[r] and no enabled write to r) or (sb_set and sb_addr==r).
  - Set wins over a same-cycle clear, because a new producer has been issued.
- rd_busy[i] is registered with the same write-first/read-first rule as rd_data:
  - WRITE_FIRST=1: rd_busy captures the post-update busy value.
  - WRITE_FIRST=0: rd_busy captures the pre-update value.
- Writes to a non-busy register are legal; the busy bit stays 0.
- No other state. No stall or handshake: reads issue every cycle.
- Reset mid-operation: pending busy bits are discarded. A write asserted in the reset cycle is lost.

Test Plan:
- Reset check: assert rst 2 cycles, then read addr 0, 2 and 5 -> rd_data 0, 4096, 0; rd_busy all 0. Then write x2=0x10 and deassert; next read of x2 -> 0x10.
- Read latency: write x5=0xDEADBEEF at cycle 1, read x5 at cycle 3 -> rd_data=0xDEADBEEF visible after edge 3 only, not after edge 2.
- Same-cycle read/write: x7=0x1 preloaded. In one cycle, write x7=0x2 and read x7 on port 0 -> rd_data=0x2 with WRITE_FIRST=1, and 0x1 with WRITE_FIRST=0.
- x0 and collision (NWR=2): write x0=0xFFFF -> read x0=0. Same cycle, port0 writes x9=0xA and port1 writes x9=0xB -> read x9=0xB.
- Scoreboard: sb_set x12 -> next-cycle read of x12 has rd_busy=1. Write x12=0x33 -> rd_busy=0 and data 0x33.
- Scoreboard collision: sb_set and a write to x12 in the same cycle -> rd_busy stays 1. Assert rst mid-pending -> rd_busy=0 for x12.
